// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu command driver: ALU operation encodings,
// driver FSM states and the packed command word held in the FIFO.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'd0,
      add_op = 3'd1,
      and_op = 3'd2,
      xor_op = 3'd3,
      mul_op = 3'd4,
      rst_op = 3'd7
   } operation_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      NOP,
      RESP
   } driver_state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

   // Encodings 5..7 are rejected without touching the ALU.
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= 3'(mul_op));
   endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Command FIFO: DEPTH x 19-bit storage, wrapping pointers, occupancy count.
// Head entry is read directly from the storage registers.
module tinyalu_cmd_fifo
   import tinyalu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  cmd_t wr_data,
   input  logic pop,
   output cmd_t rd_data,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   cmd_t           mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   // A full FIFO refuses a push even when the head is popped that cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// Upstream command stage for tinyalu: buffers commands, issues them with the
// start/done protocol and returns results. Optional watchdog: TINYALU_DRV_WATCHDOG_EN.
module tinyalu_cmd_driver
   import tinyalu_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic        alu_start,
   output logic [2:0]  alu_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic        rsp_err
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("tinyalu_cmd_driver: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
   end

   driver_state_t state;
   cmd_t          wr_cmd;
   cmd_t          head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;

   assign wr_cmd    = '{op: cmd_op, a: cmd_a, b: cmd_b};
   assign cmd_ready = !fifo_full;
   assign pop       = (state == IDLE) && !fifo_empty;

   tinyalu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (cmd_valid),
      .wr_data (wr_cmd),
      .pop     (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef TINYALU_DRV_WATCHDOG_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         alu_start  <= 1'b0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_op     <= '0;
         rsp_err    <= 1'b0;
`ifdef TINYALU_DRV_WATCHDOG_EN
         wd_cnt     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               alu_start <= 1'b0;
               if (!fifo_empty) begin
                  if (is_legal_op(head.op)) begin
                     alu_op <= head.op;
                     alu_a  <= head.a;
                     alu_b  <= head.b;
                     state  <= (head.op == no_op) ? NOP : ISSUE;
                  end else begin
                     rsp_op     <= head.op;
                     rsp_result <= '0;
                     rsp_err    <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            NOP: begin
               alu_start <= 1'b1;
               state     <= IDLE;
            end
            // First ISSUE cycle only raises start; done is honoured once start is high.
            ISSUE: begin
               if (!alu_start) begin
                  alu_start <= 1'b1;
`ifdef TINYALU_DRV_WATCHDOG_EN
                  wd_cnt    <= '0;
`endif
               end else if (alu_done) begin
                  alu_start  <= 1'b0;
                  rsp_result <= alu_result;
                  rsp_op     <= alu_op;
                  rsp_err    <= 1'b0;
                  state      <= RESP;
               end
`ifdef TINYALU_DRV_WATCHDOG_EN
               else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  alu_start  <= 1'b0;
                  rsp_result <= '0;
                  rsp_op     <= alu_op;
                  rsp_err    <= 1'b1;
                  state      <= RESP;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Directed self-checking bench for tinyalu_cmd_driver with a behavioural ALU responder.
module tb_tinyalu_cmd_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_a = '0;
   logic [7:0]  cmd_b = '0;
   logic [2:0]  cmd_op = '0;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_err;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   bit          alu_en = 1'b1;
   int unsigned wait_cnt = 0;
   int unsigned start_hi_cnt = 0;
   int unsigned start_pulses = 0;
   logic        start_prev = 1'b0;

   tinyalu_cmd_driver #(
      .DEPTH          (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_op     (rsp_op),
      .rsp_err    (rsp_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return {8'h00, a} * {8'h00, b};
         default: return 16'h0000;
      endcase
   endfunction

   // Behavioural ALU: done pulse after 0 (single-cycle ops) or 3 (mul) wait cycles.
   always @(negedge clk) begin
      alu_done = 1'b0;
      if (alu_en && alu_start && !reset) begin
         if (wait_cnt >= ((alu_op == 3'd4) ? 3 : 0)) begin
            alu_done   = 1'b1;
            alu_result = alu_calc(alu_op, alu_a, alu_b);
            wait_cnt   = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      if (alu_start) start_hi_cnt++;
      if (alu_start && !start_prev) start_pulses++;
      start_prev = alu_start;
   end

   task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1;
         cmd_op    = op;
         cmd_a     = a;
         cmd_b     = b;
         if (cmd_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output bit ok, output logic [15:0] res, output logic [2:0] op, output logic err);
      ok  = 1'b0;
      res = '0;
      op  = '0;
      err = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (rsp_valid) begin
            ok  = 1'b1;
            res = rsp_result;
            op  = rsp_op;
            err = rsp_err;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
      n_total++; if (alu_start !== 1'b0) $display("FAIL reset_alu_start: got %b expected 0", alu_start); else n_pass++;
      n_total++; if ({alu_op, alu_a, alu_b} !== 19'h0) $display("FAIL reset_alu_operands: got %h expected 0", {alu_op, alu_a, alu_b}); else n_pass++;
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
      n_total++; if ({rsp_result, rsp_op, rsp_err} !== 20'h0) $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_result, rsp_op, rsp_err}); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_add();
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_a = 8'h05; cmd_b = 8'h03;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      n_total++; if (alu_start !== 1'b0) $display("FAIL add_start_n1: got %b expected 0", alu_start); else n_pass++;
      @(negedge clk);
      n_total++; if (alu_start !== 1'b0) $display("FAIL add_start_n2: got %b expected 0", alu_start); else n_pass++;
      @(negedge clk);
      n_total++; if (alu_start !== 1'b1) $display("FAIL add_start_n3: got %b expected 1", alu_start); else n_pass++;
      n_total++; if ({alu_op, alu_a, alu_b} !== {3'd1, 8'h05, 8'h03}) $display("FAIL add_operands: got %h expected %h", {alu_op, alu_a, alu_b}, {3'd1, 8'h05, 8'h03}); else n_pass++;
      @(negedge clk);
      n_total++; if (alu_start !== 1'b0) $display("FAIL add_start_drop: got %b expected 0", alu_start); else n_pass++;
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_early: got %b expected 0", rsp_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid: got %b expected 1", rsp_valid); else n_pass++;
      n_total++; if (rsp_result !== 16'h0008) $display("FAIL add_result: got %h expected 0008", rsp_result); else n_pass++;
      n_total++; if ({rsp_op, rsp_err} !== {3'd1, 1'b0}) $display("FAIL add_op_err: got %h expected %h", {rsp_op, rsp_err}, {3'd1, 1'b0}); else n_pass++;
      @(negedge clk);
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL add_rsp_clear: got %b expected 0", rsp_valid); else n_pass++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_mul();
      bit ok; logic [15:0] res; logic [2:0] op; logic err;
      start_hi_cnt = 0; start_pulses = 0;
      send_cmd(3'd4, 8'hFF, 8'hFF, ok);
      n_total++; if (ok !== 1'b1) $display("FAIL mul_accept: got %b expected 1", ok); else n_pass++;
      get_rsp(ok, res, op, err);
      n_total++; if (ok !== 1'b1) $display("FAIL mul_rsp_timeout: got %b expected 1", ok); else n_pass++;
      n_total++; if (res !== 16'hFE01) $display("FAIL mul_result: got %h expected FE01", res); else n_pass++;
      n_total++; if ({op, err} !== {3'd4, 1'b0}) $display("FAIL mul_op_err: got %h expected %h", {op, err}, {3'd4, 1'b0}); else n_pass++;
      n_total++; if ((start_hi_cnt >= 3) !== 1'b1) $display("FAIL mul_start_hold: got %0d cycles expected >=3", start_hi_cnt); else n_pass++;
      n_total++; if (start_pulses !== 1) $display("FAIL mul_start_pulses: got %0d expected 1", start_pulses); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [2:0]  ops  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd4};
      logic [7:0]  as   [6] = '{8'h01, 8'hF0, 8'hF0, 8'h10, 8'hFF, 8'h03};
      logic [7:0]  bs   [6] = '{8'h02, 8'h3C, 8'h3C, 8'h10, 8'hFF, 8'h07};
      logic [15:0] exps [6] = '{16'h0003, 16'h0030, 16'h00CC, 16'h0100, 16'h01FE, 16'h0015};
      logic [15:0] res  [6];
      logic [2:0]  rops [6];
      bit          oks  [6];
      logic        err;
      bit          ok;
      bit          will;
      int unsigned acc = 0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         will = 1'b0;
         if (acc < 6) begin
            cmd_valid = 1'b1; cmd_op = ops[acc]; cmd_a = as[acc]; cmd_b = bs[acc];
            will = cmd_ready;
         end
         @(posedge clk);
         #1;
         if (will) acc++;
         cmd_valid = 1'b0;
      end
      n_total++; if (acc !== 5) $display("FAIL fill_accepted: got %0d expected 5", acc); else n_pass++;
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL fill_cmd_ready: got %b expected 0", cmd_ready); else n_pass++;
      get_rsp(oks[0], res[0], rops[0], err);
      send_cmd(ops[5], as[5], bs[5], ok);
      n_total++; if (ok !== 1'b1) $display("FAIL fill_sixth_accept: got %b expected 1", ok); else n_pass++;
      for (int k = 1; k < 6; k++) get_rsp(oks[k], res[k], rops[k], err);
      for (int k = 0; k < 6; k++) begin
         n_total++;
         if ({oks[k], rops[k], res[k]} !== {1'b1, ops[k], exps[k]})
            $display("FAIL order_rsp%0d: got ok=%b op=%0d res=%h expected ok=1 op=%0d res=%h", k, oks[k], rops[k], res[k], ops[k], exps[k]);
         else n_pass++;
      end
   endtask

   task automatic test_illegal_and_nop();
      bit ok; logic [15:0] res; logic [2:0] op; logic err;
      bit seen = 1'b0;
      start_hi_cnt = 0; start_pulses = 0;
      send_cmd(3'd5, 8'h12, 8'h34, ok);
      get_rsp(ok, res, op, err);
      n_total++; if ({ok, err, op, res} !== {1'b1, 1'b1, 3'd5, 16'h0000}) $display("FAIL illegal5_rsp: got ok=%b err=%b op=%0d res=%h expected ok=1 err=1 op=5 res=0000", ok, err, op, res); else n_pass++;
      send_cmd(3'd7, 8'h56, 8'h78, ok);
      get_rsp(ok, res, op, err);
      n_total++; if ({ok, err, op, res} !== {1'b1, 1'b1, 3'd7, 16'h0000}) $display("FAIL illegal7_rsp: got ok=%b err=%b op=%0d res=%h expected ok=1 err=1 op=7 res=0000", ok, err, op, res); else n_pass++;
      n_total++; if (start_pulses !== 0) $display("FAIL illegal_no_start: got %0d pulses expected 0", start_pulses); else n_pass++;
      start_hi_cnt = 0; start_pulses = 0;
      send_cmd(3'd0, 8'hAA, 8'h55, ok);
      rsp_ready = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      n_total++; if (seen !== 1'b0) $display("FAIL nop_no_rsp: got %b expected 0", seen); else n_pass++;
      n_total++; if ({start_pulses, start_hi_cnt} !== {32'd1, 32'd1}) $display("FAIL nop_start_pulse: got pulses=%0d cycles=%0d expected 1/1", start_pulses, start_hi_cnt); else n_pass++;
   endtask

   task automatic test_watchdog();
      bit ok; logic [15:0] res; logic [2:0] op; logic err;
      alu_en = 1'b0;
      start_hi_cnt = 0;
      send_cmd(3'd4, 8'h02, 8'h03, ok);
`ifdef TINYALU_DRV_WATCHDOG_EN
      get_rsp(ok, res, op, err);
      n_total++; if ({ok, err, op, res} !== {1'b1, 1'b1, 3'd4, 16'h0000}) $display("FAIL wd_rsp: got ok=%b err=%b op=%0d res=%h expected ok=1 err=1 op=4 res=0000", ok, err, op, res); else n_pass++;
      n_total++; if (start_hi_cnt !== 16) $display("FAIL wd_start_cycles: got %0d expected 16", start_hi_cnt); else n_pass++;
      alu_en = 1'b1;
`else
      repeat (40) @(negedge clk);
      n_total++; if ({alu_start, rsp_valid} !== 2'b10) $display("FAIL nowd_waiting: got start/valid=%b expected 10", {alu_start, rsp_valid}); else n_pass++;
      alu_en = 1'b1;
      get_rsp(ok, res, op, err);
      n_total++; if ({ok, err, op, res} !== {1'b1, 1'b0, 3'd4, 16'h0006}) $display("FAIL nowd_rsp: got ok=%b err=%b op=%0d res=%h expected ok=1 err=0 op=4 res=0006", ok, err, op, res); else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      bit ok; logic [15:0] res; logic [2:0] op; logic err;
      bit found = 1'b0;
      bit seen = 1'b0;
      alu_en = 1'b1;
      send_cmd(3'd4, 8'hFF, 8'hFF, ok);
      send_cmd(3'd1, 8'h01, 8'h01, ok);
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (alu_start) found = 1'b1;
      end
      n_total++; if (found !== 1'b1) $display("FAIL rstmid_start_seen: got %b expected 1", found); else n_pass++;
      reset = 1'b1;
      #1;
      n_total++; if ({alu_start, rsp_valid, cmd_ready} !== 3'b001) $display("FAIL rstmid_outputs: got start/valid/ready=%b expected 001", {alu_start, rsp_valid, cmd_ready}); else n_pass++;
      n_total++; if ({alu_op, alu_a, alu_b} !== 19'h0) $display("FAIL rstmid_operands: got %h expected 0", {alu_op, alu_a, alu_b}); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      start_pulses = 0;
      rsp_ready = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      n_total++; if ({seen, start_pulses} !== {1'b0, 32'd0}) $display("FAIL rstmid_fifo_flushed: got rsp=%b pulses=%0d expected 0/0", seen, start_pulses); else n_pass++;
      send_cmd(3'd1, 8'h07, 8'h09, ok);
      get_rsp(ok, res, op, err);
      n_total++; if ({ok, err, op, res} !== {1'b1, 1'b0, 3'd1, 16'h0010}) $display("FAIL rstmid_after: got ok=%b err=%b op=%0d res=%h expected ok=1 err=0 op=1 res=0010", ok, err, op, res); else n_pass++;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit, got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_back_to_back();
      test_illegal_and_nop();
      test_watchdog();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
